// File: rtl/img_rr_arbiter_if.sv
// img_rr_arbiter_if: slave request channels and muxed FIFO-side beat of the round-robin arbiter
interface img_rr_arbiter_if #(
   parameter int NUM_SLV = 4,
   parameter int DW      = 32,
   parameter int MODE_W  = 2,
   parameter int PV_W    = 8
);
   localparam int GW = $clog2(NUM_SLV);
   logic [NUM_SLV-1:0]        slv_data_valid;
   logic [NUM_SLV*DW-1:0]     slv_data;
   logic [NUM_SLV*MODE_W-1:0] slv_mode;
   logic [NUM_SLV*PV_W-1:0]   slv_proc_val;
   logic [NUM_SLV-1:0]        slv_ready;
   logic                      fifo_full;
   logic                      mstr_cmplt;
   logic                      slvx_data_valid;
   logic [DW-1:0]             slvx_data;
   logic [MODE_W-1:0]         slvx_mode;
   logic [PV_W-1:0]           slvx_proc_val;
   logic [GW-1:0]             gnt_id;
   logic                      busy;
   modport master (
      input  slv_data_valid, slv_data, slv_mode, slv_proc_val, fifo_full, mstr_cmplt,
      output slv_ready, slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, gnt_id, busy
   );
   modport slave (
      output slv_data_valid, slv_data, slv_mode, slv_proc_val, fifo_full, mstr_cmplt,
      input  slv_ready, slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, gnt_id, busy
   );
endinterface

// File: rtl/img_rr_arbiter.sv
// img_rr_arbiter: round-robin burst arbiter muxing slave pixel beats into one registered FIFO stream
module img_rr_arbiter #(
   parameter int NUM_SLV   = 4,
   parameter int DW        = 32,
   parameter int MODE_W    = 2,
   parameter int PV_W      = 8,
   parameter int BURST_LEN = 8
) (
   input logic               clk,
   input logic               rst,
   img_rr_arbiter_if.master  bus
);
   localparam int GW = $clog2(NUM_SLV);
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;
   logic [0:0]        r_state;
   logic [GW-1:0]     r_ptr;
   logic [GW-1:0]     r_gnt;
   logic [CW-1:0]     r_cnt;
   logic              r_xv;
   logic [DW-1:0]     r_xd;
   logic [MODE_W-1:0] r_xm;
   logic [PV_W-1:0]   r_xp;
   logic [GW-1:0]     w_win;
   logic [GW-1:0]     w_idx;
   logic              w_any;
   logic              w_open;
   logic              w_xfer;
   logic              w_last;
   assign w_open = !bus.fifo_full && !bus.mstr_cmplt && !rst;
   assign w_xfer = (r_state == BURST) && w_open && bus.slv_data_valid[r_gnt];
   assign w_last = r_cnt == CW'(BURST_LEN - 1);
   assign bus.slv_ready = ((r_state == BURST) && w_open) ? NUM_SLV'(1) << r_gnt : '0;
   assign bus.busy = r_state == BURST;
   assign bus.gnt_id = r_gnt;
   assign bus.slvx_data_valid = r_xv;
   assign bus.slvx_data = r_xd;
   assign bus.slvx_mode = r_xm;
   assign bus.slvx_proc_val = r_xp;
   // circular search from r_ptr upward; scanning downward lets the nearest requester overwrite the rest
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      w_idx = '0;
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
         w_idx = GW'((int'(r_ptr) + k) % NUM_SLV);
         if (bus.slv_data_valid[w_idx]) begin
            w_win = w_idx;
            w_any = 1'b1;
         end
      end
   end
   // arbitration FSM: one IDLE cycle per grant, burst ends on length, valid drop or master complete
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_cnt   <= '0;
      end else if (r_state == IDLE) begin
         if (w_any && w_open) begin
            r_state <= BURST;
            r_gnt   <= w_win;
            r_ptr   <= (w_win == GW'(NUM_SLV - 1)) ? '0 : w_win + 1'b1;
            r_cnt   <= '0;
         end
      end else begin
         if (w_xfer) r_cnt <= r_cnt + 1'b1;
         if (bus.mstr_cmplt || !bus.slv_data_valid[r_gnt] || (w_xfer && w_last)) r_state <= IDLE;
      end
   end
   // output register: accepted beat appears one cycle later, fields hold between transfers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xv <= 1'b0;
         r_xd <= '0;
         r_xm <= '0;
         r_xp <= '0;
      end else begin
         r_xv <= w_xfer;
         if (w_xfer) begin
            r_xd <= bus.slv_data[r_gnt*DW +: DW];
            r_xm <= bus.slv_mode[r_gnt*MODE_W +: MODE_W];
            r_xp <= bus.slv_proc_val[r_gnt*PV_W +: PV_W];
         end
      end
   end
endmodule

// File: tb/tb_img_rr_arbiter.sv
// tb_img_rr_arbiter: directed scenarios plus random stress against a cycle-level reference model
module tb_img_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int MW = 2;
   localparam int PW = 8;
   localparam int BL = 4;
   localparam int BOUND = (N - 1) * (BL + 1);
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   img_rr_arbiter_if #(.NUM_SLV(N), .DW(DW), .MODE_W(MW), .PV_W(PW)) bus ();
   img_rr_arbiter #(.NUM_SLV(N), .DW(DW), .MODE_W(MW), .PV_W(PW), .BURST_LEN(BL)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   int checks = 0;
   int errors = 0;
   logic [N-1:0] v = '0;
   logic ff = 1'b0;
   logic mc = 1'b0;
   int sent [N];
   int rcvd [N];
   int wait_c [N];
   int m_own = -1;
   int m_beats = 0;
   int m_ptr = 0;
   int m_last = 0;
   int m_src = 0;
   logic m_xv = 1'b0;
   logic [DW-1:0] m_xd = '0;
   logic [MW-1:0] m_xm = '0;
   logic [PW-1:0] m_xp = '0;
   logic pbusy = 1'b0;
   int glog [$];
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [DW-1:0] pd(int i);
      return {8'(i), 24'(sent[i])};
   endfunction
   function automatic logic [MW-1:0] pm(int i);
      return MW'(sent[i] + i);
   endfunction
   function automatic logic [PW-1:0] pp(int i);
      return PW'(sent[i] * 3 + i);
   endfunction
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.slv_data[i*DW +: DW] = pd(i);
         bus.slv_mode[i*MW +: MW] = pm(i);
         bus.slv_proc_val[i*PW +: PW] = pp(i);
      end
      bus.slv_data_valid = v;
      bus.fifo_full = ff;
      bus.mstr_cmplt = mc;
   endtask
   task automatic step();
      int win;
      int now;
      logic [N-1:0] er;
      bit elig;
      bit xfer;
      drive();
      @(negedge clk);
      elig = !ff && !mc && !rst;
      er = (m_own >= 0 && elig) ? N'(1) << m_own : '0;
      chk("busy", 64'(bus.busy), 64'(m_own >= 0));
      chk("gnt_id", 64'(bus.gnt_id), 64'(m_last));
      chk("slv_ready", 64'(bus.slv_ready), 64'(er));
      chk("slvx_valid", 64'(bus.slvx_data_valid), 64'(m_xv));
      chk("slvx_data", 64'(bus.slvx_data), 64'(m_xd));
      chk("slvx_mode", 64'(bus.slvx_mode), 64'(m_xm));
      chk("slvx_pv", 64'(bus.slvx_proc_val), 64'(m_xp));
      if (m_xv) begin
         chk("seq", 64'(bus.slvx_data[23:0]), 64'(rcvd[m_src]));
         rcvd[m_src]++;
      end
      if (bus.busy && !pbusy) glog.push_back(int'(bus.gnt_id));
      pbusy = bus.busy;
      win = -1;
      for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      now = (m_own >= 0) ? m_own : (elig ? win : -1);
      for (int i = 0; i < N; i++) begin
         if (!v[i] || rst) wait_c[i] = 0;
         else if (now == i) begin
            if (m_own < 0) chk("wait_bound", 64'(wait_c[i] <= BOUND), 64'd1);
            wait_c[i] = 0;
         end else if (elig) wait_c[i]++;
      end
      xfer = m_own >= 0 && elig && v[m_own];
      if (rst) begin
         m_own = -1; m_ptr = 0; m_last = 0; m_beats = 0;
         m_xv = 1'b0; m_xd = '0; m_xm = '0; m_xp = '0;
      end else begin
         m_xv = xfer;
         if (xfer) begin
            m_xd = pd(m_own); m_xm = pm(m_own); m_xp = pp(m_own);
            m_src = m_own;
            sent[m_own]++;
         end
         if (m_own < 0) begin
            if (win >= 0 && elig) begin
               m_own = win; m_last = win; m_ptr = (win + 1) % N; m_beats = 0;
            end
         end else begin
            if (xfer) m_beats++;
            if (mc || !v[m_own] || m_beats == BL) m_own = -1;
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic wait_busy();
      int n = 0;
      while (m_own < 0 && n < 20) begin
         step();
         n++;
      end
      chk("wait_busy_timeout", 64'(m_own >= 0), 64'd1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < N; i++) begin
         sent[i] = 0; rcvd[i] = 0; wait_c[i] = 0;
      end
      repeat (2) step();
      rst = 1'b0;
      v = 4'b0101;
      glog.delete();
      repeat (24) step();
      chk("two_req_count", 64'(glog.size() >= 3), 64'd1);
      chk("two_req_g0", 64'(glog[0]), 64'd0);
      chk("two_req_g1", 64'(glog[1]), 64'd2);
      chk("two_req_g2", 64'(glog[2]), 64'd0);
      v = '0;
      repeat (3) step();
      v = 4'b0010;
      wait_busy();
      step();
      step();
      ff = 1'b1;
      repeat (3) step();
      ff = 1'b0;
      repeat (4) step();
      v = '0;
      step();
      glog.delete();
      v = 4'b1000;
      wait_busy();
      step();
      step();
      v = 4'b0011;
      repeat (4) step();
      chk("drop_g0", 64'(glog[0]), 64'd3);
      chk("drop_next_lowest", 64'(glog[1]), 64'd0);
      v = '0;
      repeat (6) step();
      v = 4'b0100;
      wait_busy();
      step();
      step();
      mc = 1'b1;
      repeat (2) step();
      mc = 1'b0;
      repeat (6) step();
      v = '0;
      repeat (2) step();
      v = 4'b0001;
      wait_busy();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      v = 4'b1010;
      glog.delete();
      repeat (4) step();
      chk("post_rst_gnt", 64'(glog[0]), 64'd1);
      v = '0;
      repeat (6) step();
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) v[i] = ~v[i];
         ff = $urandom_range(3) == 0;
         mc = $urandom_range(63) == 0;
         step();
      end
      v = '0;
      ff = 1'b0;
      mc = 1'b0;
      repeat (4) step();
      for (int i = 0; i < N; i++) chk("lossless", 64'(rcvd[i]), 64'(sent[i]));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
